ifetch_byte_unit: RTL

- Instruction-fetch front end that sits directly upstream of the processor's decode/execute datapath.
- Reads the byte-wide instruction memory one byte per cycle and assembles big-endian 32-bit words (byte at lowest address goes to [31:24]).
- Buffers assembled words in a small prefetch FIFO and presents them to the core over a valid/ready handshake.
- Supports a redirect (branch/jump) that flushes all prefetched and in-flight state and restarts fetch at a new PC.

---
 rtl/ifetch_byte_unit.sv | 105 ++++++++++
 1 files changed

// File: rtl/ifetch_byte_unit.sv
// ifetch_byte_unit: byte-serial instruction fetch that assembles big-endian words into a prefetch FIFO.
module ifetch_byte_unit #(
  parameter int          IMEM_AW    = 5,
  parameter int          FIFO_DEPTH = 2,
  parameter logic [31:0] RESET_PC   = 32'h0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               redirect,
  input  logic [31:0]        redirect_pc,
  output logic               imem_rd,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [7:0]         imem_byte,
  output logic               inst_valid,
  input  logic               inst_ready,
  output logic [31:0]        inst,
  output logic [31:0]        inst_pc
);
  localparam int PW = FIFO_DEPTH > 1 ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  logic [31:0]   fpc_q, fpc_d;
  logic [1:0]    k_q, k_d, fk_q, fk_d;
  logic          pending_q, pending_d, fly_q, fly_d;
  logic [23:0]   asm_q, asm_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] rp_q, rp_d, wp_q, wp_d;
  logic [31:0]   word_q [FIFO_DEPTH];
  logic [31:0]   word_d [FIFO_DEPTH];
  logic [31:0]   wpc_q [FIFO_DEPTH];
  logic [31:0]   wpc_d [FIFO_DEPTH];
  logic [31:0]   inst_q, inst_d, inst_pc_q, inst_pc_d;
  logic          slot_free, issue, push, pop;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction
  // a word in progress must finish its four bytes; a new word needs a free slot
  assign slot_free  = int'(count_q) + int'(pending_q) < FIFO_DEPTH;
  assign issue      = !reset && (k_q != 2'd0 || slot_free);
  assign push       = fly_q && fk_q == 2'd3;
  assign inst_valid = count_q != '0;
  assign pop        = inst_valid && inst_ready;
  assign imem_rd    = issue;
  assign imem_addr  = fpc_q[IMEM_AW-1:0] + IMEM_AW'(k_q);
  assign inst       = inst_q;
  assign inst_pc    = inst_pc_q;
  always_comb begin
    word_d    = word_q;
    wpc_d     = wpc_q;
    fly_d     = issue;
    fk_d      = k_q;
    asm_d     = fly_q ? {asm_q[15:0], imem_byte} : asm_q;
    k_d       = issue ? k_q + 2'd1 : k_q;
    fpc_d     = (issue && k_q == 2'd3) ? fpc_q + 32'd4 : fpc_q;
    pending_d = (issue && k_q == 2'd0) ? 1'b1 : push ? 1'b0 : pending_q;
    wp_d      = push ? nxt(wp_q) : wp_q;
    rp_d      = pop ? nxt(rp_q) : rp_q;
    count_d   = count_q + CW'(push) - CW'(pop);
    if (push) begin
      word_d[wp_q] = {asm_q, imem_byte};
      wpc_d[wp_q]  = fpc_q - 32'd4;
    end
    if (redirect) begin
      fpc_d     = redirect_pc & ~32'h3;
      k_d       = 2'd0;
      pending_d = 1'b0;
      fly_d     = 1'b0;
      count_d   = '0;
      rp_d      = '0;
      wp_d      = '0;
    end
    inst_d    = (count_d != '0) ? word_d[rp_d] : inst_q;
    inst_pc_d = (count_d != '0) ? wpc_d[rp_d] : inst_pc_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fpc_q     <= RESET_PC;
      k_q       <= 2'd0;
      fk_q      <= 2'd0;
      pending_q <= 1'b0;
      fly_q     <= 1'b0;
      asm_q     <= '0;
      count_q   <= '0;
      rp_q      <= '0;
      wp_q      <= '0;
      word_q    <= '{default: '0};
      wpc_q     <= '{default: '0};
      inst_q    <= '0;
      inst_pc_q <= '0;
    end else begin
      fpc_q     <= fpc_d;
      k_q       <= k_d;
      fk_q      <= fk_d;
      pending_q <= pending_d;
      fly_q     <= fly_d;
      asm_q     <= asm_d;
      count_q   <= count_d;
      rp_q      <= rp_d;
      wp_q      <= wp_d;
      word_q    <= word_d;
      wpc_q     <= wpc_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
    end
  end
endmodule
